// File: rtl/core_pkg.sv
// Shared core definitions for the execute-stage branch logic.
// Holds the B-type funct3 encodings, the branch resolver state type and the
// taken/not-taken decode used by branch_resolver.
package core_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } br_state_t;

  // Jumps always resolve taken and win over a simultaneous branch flag.
  // The comparator already applied signedness via br_un, so signed and
  // unsigned compares share a flag.
  function automatic logic br_taken(input logic       is_branch,
                                    input logic       is_jump,
                                    input logic [2:0] funct3,
                                    input logic       eq,
                                    input logic       lt);
    logic taken;
    taken = 1'b0;
    if (is_jump) begin
      taken = 1'b1;
    end else if (is_branch) begin
      unique case (funct3)
        F3_BEQ:           taken = eq;
        F3_BNE:           taken = ~eq;
        F3_BLT, F3_BLTU:  taken = lt;
        F3_BGE, F3_BGEU:  taken = ~lt;
        default:          taken = 1'b0;
      endcase
    end
    return taken;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Bundle of the execute-stage handshake, comparator link and fetch redirect
// signals around branch_resolver.
//   master : used by branch_resolver (drives ex_ready, br_un, redirect_*,
//            flush, misalign)
//   slave  : used by the surrounding execute/fetch logic
interface branch_resolver_if #(
  parameter int unsigned XLEN = 32
);
  logic            ex_valid;
  logic            ex_ready;
  logic            ex_is_branch;
  logic            ex_is_jump;
  logic [2:0]      ex_funct3;
  logic [XLEN-1:0] ex_target;
  logic            br_un;
  logic            br_eq;
  logic            br_lt;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            misalign;

  modport master (
    input  ex_valid, ex_is_branch, ex_is_jump, ex_funct3, ex_target,
    input  br_eq, br_lt, redirect_ready,
    output ex_ready, br_un, redirect_valid, redirect_pc, flush, misalign
  );

  modport slave (
    output ex_valid, ex_is_branch, ex_is_jump, ex_funct3, ex_target,
    output br_eq, br_lt, redirect_ready,
    input  ex_ready, br_un, redirect_valid, redirect_pc, flush, misalign
  );
endinterface

// File: rtl/branch_resolver.sv
// Execute-stage branch resolution unit.
// Decides taken/not-taken for branches and jumps, issues a held PC redirect
// to fetch (valid/ready) and then holds flush for FLUSH_CYCLES cycles in
// total after the redirect is accepted. Misaligned taken targets raise a
// one-cycle misalign pulse instead of redirecting.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : branch_resolver_if.master (ex_*, br_*, redirect_*, flush, misalign)
//   stat_branches, stat_taken : statistics counters, present only when
//                               BRANCH_RESOLVER_STATS_EN is defined
// FLUSH_CYCLES legal range is 1..15.
module branch_resolver
  import core_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  branch_resolver_if.master   bus
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_taken
`endif
);

  br_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            misalign_q, misalign_d;
  logic            accept;
  logic            taken;
  logic            aligned;

  assign accept  = (state_q == IDLE) && bus.ex_valid;
  assign taken   = br_taken(bus.ex_is_branch, bus.ex_is_jump, bus.ex_funct3,
                            bus.br_eq, bus.br_lt);
  assign aligned = (bus.ex_target[1:0] == 2'b00);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && taken) begin
          if (aligned) begin
            pc_d    = bus.ex_target;
            state_d = REDIRECT;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          // The REDIRECT cycle itself counts as the first flush cycle.
          if (FLUSH_CYCLES <= 1) begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end else begin
            cnt_d   = 4'(FLUSH_CYCLES - 1);
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      cnt_q      <= 4'd0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  assign bus.ex_ready       = (state_q == IDLE);
  assign bus.br_un          = bus.ex_funct3[1];
  assign bus.redirect_valid = (state_q == REDIRECT);
  assign bus.redirect_pc    = pc_q;
  assign bus.flush          = (state_q != IDLE);
  assign bus.misalign       = misalign_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_taken_q, stat_taken_d;

  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_taken_d    = stat_taken_q;
    if (accept && (bus.ex_is_branch || bus.ex_is_jump)) begin
      stat_branches_d = stat_branches_q + 32'd1;
    end
    if (accept && taken && aligned) begin
      stat_taken_d = stat_taken_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q <= 32'd0;
      stat_taken_q    <= 32'd0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_taken_q    <= stat_taken_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_taken    = stat_taken_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: stimulus pushes expected redirect /
// misalign events, a negedge monitor pops and compares them.
module tb_branch_resolver;

  logic clk;
  logic rst;

  branch_resolver_if #(.XLEN(32)) bus ();

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;
`endif

  branch_resolver #(
    .XLEN        (32),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .stat_branches(stat_branches),
    .stat_taken   (stat_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        mis;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_branches = 0;
  int   exp_taken_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input logic mis, input logic [31:0] pc);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got mis=%0d pc=0x%0h expected no event", mis, pc);
    end else begin
      total--;
      e = exp_q.pop_front();
      check("event_kind", {31'd0, mis}, {31'd0, e.mis});
      if (!mis) check("redirect_pc", pc, e.pc);
    end
  endtask

  // Monitor: redirect handshakes, misalign pulses and redirect hold stability.
  logic        prev_valid, prev_ready, prev_rst;
  logic [31:0] prev_pc;
  initial begin
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_rst   = 1'b1;
    prev_pc    = '0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.redirect_valid && bus.redirect_ready) pop_check(1'b0, bus.redirect_pc);
      if (bus.misalign) begin
        pop_check(1'b1, 32'd0);
        check("misalign_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
      end
      if (prev_valid && !prev_ready && !prev_rst) begin
        check("hold_valid", {31'd0, bus.redirect_valid}, 32'd1);
        check("hold_pc", bus.redirect_pc, prev_pc);
      end
    end
    prev_valid <= bus.redirect_valid;
    prev_ready <= bus.redirect_ready;
    prev_rst   <= rst;
    prev_pc    <= bus.redirect_pc;
  end

  task automatic issue(input logic br, input logic jmp, input logic [2:0] f3,
                       input logic eq, input logic lt, input logic [31:0] tgt,
                       input logic exp_tk, input logic exp_un);
    @(posedge clk); #1;
    bus.ex_is_branch = br;
    bus.ex_is_jump   = jmp;
    bus.ex_funct3    = f3;
    bus.br_eq        = eq;
    bus.br_lt        = lt;
    bus.ex_target    = tgt;
    bus.ex_valid     = 1'b1;
    #1;
    check("br_un", {31'd0, bus.br_un}, {31'd0, exp_un});
    @(posedge clk); #1;
    bus.ex_valid     = 1'b0;
    bus.ex_is_branch = 1'b0;
    bus.ex_is_jump   = 1'b0;
    if (br || jmp) exp_branches++;
    if (exp_tk) begin
      if (tgt[1:0] == 2'b00) begin
        exp_q.push_back('{mis: 1'b0, pc: tgt});
        exp_taken_cnt++;
      end else begin
        exp_q.push_back('{mis: 1'b1, pc: tgt});
      end
    end
  endtask

  task automatic wait_flush(input int exp_n);
    int n = 0;
    while (bus.flush && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    check("flush_cycles", n, exp_n);
    check("ready_after_flush", {31'd0, bus.ex_ready}, 32'd1);
  endtask

  task automatic check_stats();
`ifdef BRANCH_RESOLVER_STATS_EN
    check("stat_branches", stat_branches, exp_branches);
    check("stat_taken", stat_taken, exp_taken_cnt);
`endif
  endtask

  // br, jmp, f3, eq, lt, target, taken, br_un
  typedef struct packed {
    logic        br;
    logic        jmp;
    logic [2:0]  f3;
    logic        eq;
    logic        lt;
    logic [31:0] tgt;
    logic        tk;
    logic        un;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h0000_0100, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 3'b110, 1'b0, 1'b0, 32'h0000_0104, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 3'b001, 1'b1, 1'b0, 32'h0000_0108, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b0, 32'h0000_010C, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 3'b100, 1'b0, 1'b1, 32'h0000_0110, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 3'b111, 1'b0, 1'b1, 32'h0000_0114, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 3'b101, 1'b1, 1'b0, 32'h0000_0118, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 32'h0000_011C, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 32'h0000_0120, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 3'b011, 1'b0, 1'b0, 32'h0000_0124, 1'b1, 1'b1};

    rst                = 1'b1;
    bus.ex_valid       = 1'b0;
    bus.ex_is_branch   = 1'b0;
    bus.ex_is_jump     = 1'b0;
    bus.ex_funct3      = 3'b000;
    bus.ex_target      = '0;
    bus.br_eq          = 1'b0;
    bus.br_lt          = 1'b0;
    bus.redirect_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    check("reset_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    check("reset_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("reset_flush", {31'd0, bus.flush}, 32'd0);
    check("reset_misalign", {31'd0, bus.misalign}, 32'd0);
    check("reset_redirect_pc", bus.redirect_pc, 32'd0);
    check_stats();

    // Directed decode vectors with redirect_ready tied high.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].br, vecs[i].jmp, vecs[i].f3, vecs[i].eq, vecs[i].lt,
            vecs[i].tgt, vecs[i].tk, vecs[i].un);
      if (vecs[i].tk) begin
        check("redirect_next_cycle", {31'd0, bus.redirect_valid}, 32'd1);
        check("redirect_pc_direct", bus.redirect_pc, vecs[i].tgt);
        wait_flush(2);
      end else begin
        check("nt_redirect_valid", {31'd0, bus.redirect_valid}, 32'd0);
        check("nt_flush", {31'd0, bus.flush}, 32'd0);
        check("nt_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
      end
    end
    check_stats();

    // Fetch stalls the redirect for 4 cycles; ex_valid pulses are ignored.
    bus.redirect_ready = 1'b0;
    issue(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h0000_0200, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", {31'd0, bus.redirect_valid}, 32'd1);
      check("stall_pc", bus.redirect_pc, 32'h0000_0200);
      bus.ex_is_jump = 1'b1;
      bus.ex_target  = 32'h0000_0300;
      bus.ex_valid   = 1'b1;
      @(posedge clk); #1;
    end
    bus.ex_valid       = 1'b0;
    bus.ex_is_jump     = 1'b0;
    bus.redirect_ready = 1'b1;
    wait_flush(2);

    // Misaligned taken target.
    issue(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h0000_0102, 1'b1, 1'b0);
    check("mis_pulse", {31'd0, bus.misalign}, 32'd1);
    check("mis_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
    check("mis_ex_ready", {31'd0, bus.ex_ready}, 32'd1);
    @(posedge clk); #1;
    check("mis_pulse_end", {31'd0, bus.misalign}, 32'd0);
    check_stats();

    // Reset while a redirect is waiting: the redirect is dropped.
    bus.redirect_ready = 1'b0;
    issue(1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'h0000_0500, 1'b1, 1'b0);
    check("pre_rst_pc", bus.redirect_pc, 32'h0000_0500);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_redir_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_redir_pc", bus.redirect_pc, 32'd0);
    check("rst_redir_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_redir_ready", {31'd0, bus.ex_ready}, 32'd1);
    rst = 1'b0;
    exp_q.delete();
    exp_branches  = 0;
    exp_taken_cnt = 0;
    check_stats();
    bus.redirect_ready = 1'b1;

    // Reset during FLUSH.
    issue(1'b1, 1'b0, 3'b000, 1'b1, 1'b0, 32'h0000_0400, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("in_flush", {31'd0, bus.flush}, 32'd1);
    check("in_flush_ready", {31'd0, bus.ex_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_flush_flush", {31'd0, bus.flush}, 32'd0);
    check("rst_flush_valid", {31'd0, bus.redirect_valid}, 32'd0);
    check("rst_flush_ready", {31'd0, bus.ex_ready}, 32'd1);
    rst = 1'b0;
    exp_branches  = 0;
    exp_taken_cnt = 0;
    check_stats();

    @(posedge clk); #1;
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
